// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared widths, types and pointer helper for the register file write arbiter
package rf_arb_pkg;

    localparam int RF_AW       = 5;
    localparam int RF_DW       = 32;
    localparam int RF_NREQ_MAX = 8;

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

    // Advance a round-robin index with wrap for any (not just power-of-two) count.
    function automatic int unsigned rr_wrap_inc(input int unsigned i, input int unsigned n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or after ptr, wrapping
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    // Walking offsets from ptr is the rotate / priority / unrotate chain folded into one loop.
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter for the register file write port; RF_ARB_ZERO_GUARD_EN suppresses writes to register 0
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]  req_ready,
    input  logic             wr_hold,
    output logic             regW,
    output logic [AW-1:0]    wrA,
    output logic [DW-1:0]    wrD,
    output logic             busy
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            regw_q, regw_d;
    logic [AW-1:0]   wra_q, wra_d;
    logic [DW-1:0]   wrd_q, wrd_d;

    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Ready depends only on valid, ptr, hold and reset; address/data never feed it.
    assign req_ready = (rst || wr_hold) ? '0 : pick_gnt;
    assign xfer      = pick_any & ~wr_hold & ~rst;
    assign sel_addr  = req_addr[int'(pick_idx)*AW +: AW];
    assign sel_data  = req_data[int'(pick_idx)*DW +: DW];

    always_comb begin
        ptr_d  = ptr_q;
        regw_d = 1'b0;
        wra_d  = wra_q;
        wrd_d  = wrd_q;
        if (xfer) begin
            ptr_d = PW'(rr_wrap_inc(32'(pick_idx), NREQ));
            wra_d = sel_addr;
            wrd_d = sel_data;
`ifdef RF_ARB_ZERO_GUARD_EN
            regw_d = (sel_addr != '0);
`else
            regw_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            regw_q <= 1'b0;
            wra_q  <= '0;
            wrd_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            regw_q <= regw_d;
            wra_q  <= wra_d;
            wrd_q  <= wrd_d;
        end
    end

    assign regW = regw_q;
    assign wrA  = wra_q;
    assign wrD  = wrd_q;
    assign busy = regw_q | (|req_valid);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - table-driven and scoreboard bench for rf_write_arbiter with a negedge register file model
module tb_rf_write_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
`ifdef RF_ARB_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              wr_hold;
    logic              regW;
    logic [AW-1:0]     wrA;
    logic [DW-1:0]     wrD;
    logic              busy;

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_hold   (wr_hold),
        .regW      (regW),
        .wrA       (wrA),
        .wrD       (wrD),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] rf [32] = '{default: '0};
    always @(negedge clk) begin
        if (regW) rf[wrA] <= wrD;
    end

    typedef struct {
        logic [2:0]  valid;
        logic        hold;
        logic [14:0] addr;
        logic [95:0] data;
        logic [2:0]  exp_ready;
    } vec_t;

    typedef struct {
        logic        regw;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;

    exp_t        sb[$];
    logic [4:0]  last_wa;
    logic [31:0] last_wd;
    int          n_checks = 0;
    int          n_errors = 0;
    vec_t        tbl[13];

    function automatic vec_t mk(input logic [2:0] v, input logic h,
                                input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [2:0] er);
        vec_t r;
        r.valid = v;
        r.hold = h;
        r.addr = {a2, a1, a0};
        r.data = {d2, d1, d0};
        r.exp_ready = er;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_valid = v.valid;
        wr_hold   = v.hold;
        req_addr  = v.addr;
        req_data  = v.data;
    endtask

    task automatic expect_cycle(input vec_t v, input string name);
        exp_t e;
        #1;
        chk({name, " req_ready"}, 64'(req_ready), 64'(v.exp_ready));
        e.regw = 1'b0;
        e.wa = last_wa;
        e.wd = last_wd;
        for (int i = 0; i < NREQ; i++) begin
            if (v.exp_ready[i]) begin
                e.wa = v.addr[i*AW +: AW];
                e.wd = v.data[i*DW +: DW];
                e.regw = GUARD ? (e.wa != 5'd0) : 1'b1;
            end
        end
        last_wa = e.wa;
        last_wd = e.wd;
        sb.push_back(e);
    endtask

    task automatic step(input string name);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({name, " scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({name, " regW"}, 64'(regW), 64'(e.regw));
            chk({name, " wrA"}, 64'(wrA), 64'(e.wa));
            chk({name, " wrD"}, 64'(wrD), 64'(e.wd));
            chk({name, " busy"}, 64'(busy), 64'(e.regw | (|req_valid)));
        end
    endtask

    task automatic run(input vec_t v, input string name);
        drive(v);
        expect_cycle(v, name);
        step(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b001);
        tbl[1]  = mk(3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b010);
        tbl[2]  = mk(3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b100);
        tbl[3]  = mk(3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b001);
        tbl[4]  = mk(3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b010);
        tbl[5]  = mk(3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b100);
        tbl[6]  = mk(3'b101, 1'b0, 5'd1, 5'd2, 5'd3, 32'h101, 32'h202, 32'h303, 3'b001);
        tbl[7]  = mk(3'b101, 1'b0, 5'd1, 5'd2, 5'd3, 32'h101, 32'h202, 32'h303, 3'b100);
        tbl[8]  = mk(3'b010, 1'b0, 5'd0, 5'd7, 5'd0, 32'h0, 32'h64, 32'h0, 3'b010);
        tbl[9]  = mk(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000);
        tbl[10] = mk(3'b011, 1'b0, 5'd10, 5'd11, 5'd0, 32'hA0, 32'hB0, 32'h0, 3'b001);
        tbl[11] = mk(3'b011, 1'b0, 5'd10, 5'd11, 5'd0, 32'hA0, 32'hB0, 32'h0, 3'b010);
        tbl[12] = mk(3'b001, 1'b1, 5'd12, 5'd0, 5'd0, 32'hC0, 32'h0, 32'h0, 3'b000);

        last_wa = '0;
        last_wd = '0;
        rst = 1'b1;
        wr_hold = 1'b0;
        req_valid = 3'b111;
        req_addr = {5'd3, 5'd2, 5'd1};
        req_data = '1;
        #2;
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("reset regW", 64'(regW), 64'd0);
        chk("reset wrA", 64'(wrA), 64'd0);
        chk("reset wrD", 64'(wrD), 64'd0);
        chk("reset busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 13; k++) begin
            run(tbl[k], $sformatf("vec%0d", k));
        end
        chk("rf[7]", 64'(rf[7]), 64'h64);
        chk("rf[1]", 64'(rf[1]), 64'h101);
        chk("rf[3]", 64'(rf[3]), 64'h303);
        chk("rf[11]", 64'(rf[11]), 64'hB0);

        // wr_hold after a grant: the registered write still lands, later grants wait
        run(mk(3'b001, 1'b0, 5'd4, 5'd0, 5'd0, 32'h444, 32'h0, 32'h0, 3'b001), "hold_pre");
        run(mk(3'b001, 1'b1, 5'd4, 5'd0, 5'd0, 32'h555, 32'h0, 32'h0, 3'b000), "hold_c1");
        chk("hold rf[4]", 64'(rf[4]), 64'h444);
        run(mk(3'b001, 1'b1, 5'd4, 5'd0, 5'd0, 32'h555, 32'h0, 32'h0, 3'b000), "hold_c2");
        run(mk(3'b001, 1'b0, 5'd4, 5'd0, 5'd0, 32'h555, 32'h0, 32'h0, 3'b001), "hold_rel");
        @(negedge clk);
        #1;
        chk("hold_rel rf[4]", 64'(rf[4]), 64'h555);

        run(mk(3'b001, 1'b0, 5'd0, 5'd0, 5'd0, 32'h1F4, 32'h0, 32'h0, 3'b001), "zero");
        @(negedge clk);
        #1;
        chk("zero rf[0]", 64'(rf[0]), GUARD ? 64'h0 : 64'h1F4);

        // reset lands between the registering posedge and the commit negedge
        run(mk(3'b001, 1'b0, 5'd9, 5'd0, 5'd0, 32'h999, 32'h0, 32'h0, 3'b001), "rst_pre");
        rst = 1'b1;
        #1;
        chk("rst_mid regW", 64'(regW), 64'd0);
        chk("rst_mid wrA", 64'(wrA), 64'd0);
        chk("rst_mid wrD", 64'(wrD), 64'd0);
        chk("rst_mid req_ready", 64'(req_ready), 64'd0);
        last_wa = '0;
        last_wd = '0;
        @(negedge clk);
        #1;
        chk("rst_mid rf[9]", 64'(rf[9]), 64'h0);
        rst = 1'b0;
        run(mk(3'b011, 1'b0, 5'd13, 5'd14, 5'd0, 32'hD0, 32'hE0, 32'h0, 3'b001), "rst_ptr");
        run(mk(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000), "drain");
        chk("rst_ptr rf[13]", 64'(rf[13]), 64'hD0);
        chk("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Round-robin arbiter sharing the register file's single write port among several writeback requesters (ALU writeback, load writeback, multiply/divide unit). Each requester presents address and data under a valid/ready handshake. At most one request is granted per cycle, and the grant is registered into the `regW`/`wrA`/`wrD` inputs of the register file. The register file commits on the falling edge, so each registered write is stable half a cycle before it is committed.

## Interface
- `NREQ`, 3: number of write requesters, 2..8.
- `AW`, 5: register address width.
- `DW`, 32: write data width.

- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_addr`  in  NREQ*AW  packed destination addresses; requester i at bits [i*AW +: AW].
- `req_data`  in  NREQ*DW  packed write data; requester i at bits [i*DW +: DW].
- `req_ready`  out  NREQ  one-hot-or-zero grant, combinational.
- `wr_hold`  in  1  freeze: no grants while high.
- `regW`  out  1  register file write enable, registered.
- `wrA`  out  AW  register file write address, registered.
- `wrD`  out  DW  register file write data, registered.
- `busy`  out  1  high when `regW` is high or any `req_valid` is high.

## Operation
- Round-robin pointer `ptr` ranges 0..NREQ-1 and resets to 0.
- Search order is `ptr`, `ptr`+1, …, wrapping modulo NREQ. The first requester with valid high is granted.
- Transfer for requester i occurs when `req_valid[i]` and `req_ready[i]` are both high at a posedge.
- `req_ready[i]` = grant[i] & ~`wr_hold`. At most one bit is high.
- On a transfer from requester i:
  - `ptr` becomes (i+1) mod NREQ.
  - `wrA`/`wrD` load that requester's address and data.
  - `regW` goes high.
- No transfer (no valid, or `wr_hold` high):
  - `regW` goes low.
  - `wrA`/`wrD` hold their previous values.
  - `ptr` is unchanged.
- Requesters hold valid, address and data stable until ready. The arbiter does not depend on this for correctness, but data is sampled only in the transfer cycle.
- Dropping `req_valid` before it is granted is legal. Nothing is recorded.
- `wr_hold` asserted mid-stream blocks the next grant only. A write already registered still completes at the following negedge.
- Reset mid-operation: all outputs and `ptr` clear immediately. A registered write that has not yet passed its negedge is lost.
- Reset values: `regW`=0, `wrA`=0, `wrD`=0, `ptr`=0. `req_ready` is 0 while `rst` is high.

## Timing
- Request-to-commit latency: valid at posedge N with ready high → `regW`/`wrA`/`wrD` valid from posedge N to N+1 → register file commits at the negedge between them.
- Throughput is one write per cycle. Back-to-back grants to different requesters produce consecutive `regW` pulses with no bubble.
- A single requester that holds valid continuously is granted every cycle when it is the only one requesting.
- With all NREQ requesters continuously valid, each is granted exactly once per NREQ cycles. Worst-case wait is NREQ-1 cycles.
- `req_ready` is combinational from `req_valid`, `ptr`, `wr_hold` and `rst`. No path runs from `req_addr` or `req_data` to `req_ready`.

## Configuration
- `RF_ARB_ZERO_GUARD_EN` defined:
  - A transfer whose address is 0 is accepted normally: ready high, `ptr` advances.
  - `regW` is registered as 0, so register 0 is never written.
  - `wrA`/`wrD` still load the request values.
- Undefined: address 0 is treated like any other address, and `regW` pulses high.

## Structure
- Package `rf_arb_pkg` holds:
  - constants `RF_AW`=5, `RF_DW`=32 and `RF_NREQ_MAX`=8;
  - typedef `rf_addr_t` (logic [RF_AW-1:0]);
  - typedef `rf_data_t` (logic [RF_DW-1:0]).
- Sub-module `rr_pick`: combinational rotate-priority-unrotate. Inputs are the request vector and `ptr`. Outputs are the one-hot grant and its index.
- The top level holds the pointer, the output registers, the hold gating and the zero guard.

## Test plan
- Reset release, then requester 1 alone with addr 7, data 0x0000_0064 → `req_ready`=010 that cycle; next cycle `regW`=1, `wrA`=7, `wrD`=0x64; register 7 reads 0x64 after the negedge.
- All 3 requesters valid for 6 cycles, addrs 1/2/3 → grant order 0,1,2,0,1,2; `regW` high for 6 consecutive cycles.
- After requester 2 is granted (`ptr`=0), requesters 0 and 2 are both valid → requester 0 is granted first, then 2.
- `wr_hold` high for 2 cycles while requester 0 is valid → `req_ready`=000 and `regW`=0 for those cycles; requester 0 is granted in the first cycle after release.
- Requester 0 writes addr 0, data 0x1F4 → with `RF_ARB_ZERO_GUARD_EN`, `regW`=0 and register 0 is unchanged; without it, `regW`=1 and register 0 = 0x1F4.
- `rst` pulsed while `regW`=1 before the negedge → `regW`/`wrA`/`wrD` clear immediately, the target register is unchanged, and `ptr` returns to 0.
